// File: rtl/hit_frame_decoder.sv
// hit_frame_decoder: turns the tagged hit stream into per-row hit bitmaps held in
// an external sync-read row RAM. Hits to the same row are OR-accumulated through a
// two-stage read-modify-write pipeline. Writes that are still in flight are forwarded
// into the merge. The finished frame is held for readout, the RAM is sweep-cleared,
// and mem_clr then pulses for one cycle.
// Optional build macro: HIT_FRAME_DECODER_ROWMASK_EN adds the row_hit occupancy output.
module hit_frame_decoder #(
    parameter int          NCOL    = 39,
    parameter int          NROW    = 40,
    parameter int          ROW_OFS = 1,
    parameter int          DEPTH   = NROW + 3,
    parameter int          AW      = $clog2(DEPTH),
    parameter logic [15:0] SOF_TAG = 16'hAAAA,
    parameter logic [15:0] EOF_TAG = 16'h5555
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [15:0]     tag,
    input  logic [5:0]      x,
    input  logic [5:0]      y,
    input  logic            c,
    input  logic            dv,
    output logic            in_ready,
    output logic [AW-1:0]   raddr,
    input  logic [NCOL-1:0] rdata,
    output logic [AW-1:0]   waddr,
    output logic [NCOL-1:0] wdata,
    output logic            we,
    output logic            frame_rdy,
    input  logic            rd_done,
    output logic            mem_clr,
    output logic [15:0]     drop_cnt
`ifdef HIT_FRAME_DECODER_ROWMASK_EN
    ,
    output logic [NROW-1:0] row_hit
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_ACQ, S_DRAIN0, S_DRAIN1, S_HOLD, S_CLEAR} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   raddr_q, raddr_d;
    logic            s1_vld_q, s1_vld_d;
    logic [5:0]      s1_x_q, s1_x_d;
    logic            s2_vld_q;
    logic [5:0]      s2_x_q;
    logic [AW-1:0]   s2_row_q;
    logic            we_q, we_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [NCOL-1:0] wdata_q, wdata_d;
    logic            wp_we_q;
    logic [AW-1:0]   wp_addr_q;
    logic [NCOL-1:0] wp_data_q;
    logic            frame_rdy_q;
    logic            mem_clr_q, mem_clr_d;
    logic [15:0]     drop_q, drop_d;
    logic [AW:0]     clr_cnt_q, clr_cnt_d;
    logic            in_range;
    logic [NCOL-1:0] merge_base;
    logic [NCOL-1:0] hit_bit;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [AW-1:0] row_of(input logic [5:0] yy);
        return AW'(int'(yy) + ROW_OFS);
    endfunction

    assign in_range = (int'(x) < NCOL) && (int'(y) < NROW);

    // Next-state, hit capture, drop counting, clear sweep and write-stage merge
    always_comb begin
        state_d    = state_q;
        raddr_d    = raddr_q;
        s1_vld_d   = 1'b0;
        s1_x_d     = s1_x_q;
        drop_d     = drop_q;
        clr_cnt_d  = clr_cnt_q;
        mem_clr_d  = 1'b0;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        merge_base = rdata;
        hit_bit    = '0;

        unique case (state_q)
            S_IDLE: begin
                if (tag == SOF_TAG) begin
                    state_d = S_ACQ;
                    drop_d  = '0;
                end
            end
            S_ACQ: begin
                // Marker cycles never carry a hit.
                if (tag == SOF_TAG) begin
                    drop_d = '0;
                end else if (tag == EOF_TAG) begin
                    state_d = S_DRAIN0;
                end else if (dv && c) begin
                    if (in_range) begin
                        s1_vld_d = 1'b1;
                        s1_x_d   = x;
                        raddr_d  = row_of(y);
                    end else begin
                        drop_d = sat_inc(drop_q);
                    end
                end
            end
            S_DRAIN0: begin
                state_d = S_DRAIN1;
                if (dv && c) drop_d = sat_inc(drop_q);
            end
            S_DRAIN1: begin
                state_d = S_HOLD;
                if (dv && c) drop_d = sat_inc(drop_q);
            end
            S_HOLD: begin
                if (dv && c) drop_d = sat_inc(drop_q);
                if (rd_done) begin
                    state_d   = S_CLEAR;
                    clr_cnt_d = '0;
                    raddr_d   = '0;
                end
            end
            S_CLEAR: begin
                if (dv && c) drop_d = sat_inc(drop_q);
                raddr_d = '0;
                // The last row was issued on the previous cycle; finish once it is on the bus.
                if (int'(clr_cnt_q) == DEPTH) begin
                    state_d   = S_IDLE;
                    mem_clr_d = 1'b1;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A write on the bus now, or the one committed alongside our read, is newer than rdata.
        if (we_q && (waddr_q == s2_row_q)) begin
            merge_base = wdata_q;
        end else if (wp_we_q && (wp_addr_q == s2_row_q)) begin
            merge_base = wp_data_q;
        end
        hit_bit[s2_x_q] = 1'b1;

        if ((state_q == S_CLEAR) && (int'(clr_cnt_q) < DEPTH)) begin
            we_d    = 1'b1;
            waddr_d = clr_cnt_q[AW-1:0];
            wdata_d = '0;
        end else if (s2_vld_q) begin
            we_d    = 1'b1;
            waddr_d = s2_row_q;
            wdata_d = merge_base | hit_bit;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Pipeline, RAM port and status registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            raddr_q     <= '0;
            s1_vld_q    <= 1'b0;
            s1_x_q      <= '0;
            s2_vld_q    <= 1'b0;
            s2_x_q      <= '0;
            s2_row_q    <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            wp_we_q     <= 1'b0;
            wp_addr_q   <= '0;
            wp_data_q   <= '0;
            frame_rdy_q <= 1'b0;
            mem_clr_q   <= 1'b0;
            drop_q      <= '0;
            clr_cnt_q   <= '0;
        end else begin
            raddr_q     <= raddr_d;
            s1_vld_q    <= s1_vld_d;
            s1_x_q      <= s1_x_d;
            s2_vld_q    <= s1_vld_q;
            s2_x_q      <= s1_x_q;
            s2_row_q    <= raddr_q;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            wp_we_q     <= we_q;
            wp_addr_q   <= waddr_q;
            wp_data_q   <= wdata_q;
            frame_rdy_q <= (state_d == S_HOLD);
            mem_clr_q   <= mem_clr_d;
            drop_q      <= drop_d;
            clr_cnt_q   <= clr_cnt_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE) || (state_q == S_ACQ);
    assign raddr     = raddr_q;
    assign waddr     = waddr_q;
    assign wdata     = wdata_q;
    assign we        = we_q;
    assign frame_rdy = frame_rdy_q;
    assign mem_clr   = mem_clr_q;
    assign drop_cnt  = drop_q;

`ifdef HIT_FRAME_DECODER_ROWMASK_EN
    logic [NROW-1:0] row_hit_q, row_hit_d;

    // Row occupancy: wiped at frame start and at clear entry, set as each hit row is written
    always_comb begin
        row_hit_d = row_hit_q;
        if (((state_q == S_IDLE) || (state_q == S_ACQ)) && (tag == SOF_TAG)) begin
            row_hit_d = '0;
        end else if ((state_q == S_HOLD) && rd_done) begin
            row_hit_d = '0;
        end
        if (s2_vld_q) begin
            for (int r = 0; r < NROW; r++) begin
                if (int'(s2_row_q) == r + ROW_OFS) row_hit_d[r] = 1'b1;
            end
        end
    end

    // Row occupancy register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) row_hit_q <= '0;
        else        row_hit_q <= row_hit_d;
    end

    assign row_hit = row_hit_q;
`endif

endmodule

// File: tb/tb_hit_frame_decoder.sv
// Bench for hit_frame_decoder: behavioural sync-read RAM, bitmap model and write scoreboard.
module tb_hit_frame_decoder;
    localparam int          NCOL    = 39;
    localparam int          NROW    = 40;
    localparam int          ROW_OFS = 1;
    localparam int          DEPTH   = NROW + 3;
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [15:0] SOF     = 16'hAAAA;
    localparam logic [15:0] EOF     = 16'h5555;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [15:0]     tag = '0;
    logic [5:0]      x = '0;
    logic [5:0]      y = '0;
    logic            c = 1'b0;
    logic            dv = 1'b0;
    logic            in_ready;
    logic [AW-1:0]   raddr;
    logic [NCOL-1:0] rdata = '0;
    logic [AW-1:0]   waddr;
    logic [NCOL-1:0] wdata;
    logic            we;
    logic            frame_rdy;
    logic            rd_done = 1'b0;
    logic            mem_clr;
    logic [15:0]     drop_cnt;
`ifdef HIT_FRAME_DECODER_ROWMASK_EN
    logic [NROW-1:0] row_hit;
`endif

    hit_frame_decoder dut (
        .clk(clk), .reset(reset), .tag(tag), .x(x), .y(y), .c(c), .dv(dv),
        .in_ready(in_ready), .raddr(raddr), .rdata(rdata), .waddr(waddr),
        .wdata(wdata), .we(we), .frame_rdy(frame_rdy), .rd_done(rd_done),
        .mem_clr(mem_clr), .drop_cnt(drop_cnt)
`ifdef HIT_FRAME_DECODER_ROWMASK_EN
        , .row_hit(row_hit)
`endif
    );

    always #5 clk = ~clk;

    // Sync-read RAM, read-old-data on a simultaneous write
    logic [NCOL-1:0] mem [0:63] = '{default: '0};
    always @(posedge clk) begin
        rdata <= mem[raddr];
        if (we) mem[waddr] <= wdata;
    end

    typedef struct {
        logic [AW-1:0]   addr;
        logic [NCOL-1:0] data;
    } wr_t;

    typedef struct {
        int x;
        int y;
        bit c;
        bit acc;
        bit drp;
    } vec_t;

    wr_t             sb_q[$];
    wr_t             mon_e;
    logic [NCOL-1:0] model [0:63];
    int              n_checks = 0;
    int              n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Every RAM write must match the oldest expected write
    always @(negedge clk) begin
        if (reset && we) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: got waddr=%0d wdata=0x%0h, expected no write", waddr, wdata);
            end else begin
                mon_e = sb_q.pop_front();
                chk("wr_addr", 64'(waddr), 64'(mon_e.addr));
                chk("wr_data", 64'(wdata), 64'(mon_e.data));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        tag = '0; dv = 1'b0; c = 1'b0; x = '0; y = '0;
    endtask

    task automatic drive_hit(input int hx, input int hy, input bit hc);
        tag = '0; dv = 1'b1; c = hc; x = 6'(hx); y = 6'(hy);
    endtask

    task automatic expect_write(input int hx, input int hy);
        int row;
        logic [NCOL-1:0] b;
        row = hy + ROW_OFS;
        b = '0;
        b[hx] = 1'b1;
        model[row] = model[row] | b;
        sb_q.push_back('{addr: AW'(row), data: model[row]});
    endtask

    task automatic push_clear();
        for (int r = 0; r < DEPTH; r++) begin
            model[r] = '0;
            sb_q.push_back('{addr: AW'(r), data: '0});
        end
    endtask

    task automatic sof();
        idle_in(); tag = SOF; step(); tag = '0;
    endtask

    task automatic eof_to_hold();
        idle_in(); tag = EOF; step(); tag = '0; step(); step();
    endtask

    task automatic wait_memclr(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (mem_clr) ok = 1'b1;
        end
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s_timeout: mem_clr=0 after 200 cycles, expected 1", name);
        if (ok) begin
            chk({name, "_all_rows"}, 64'(sb_q.size()), 64'd0);
            chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
            chk({name, "_we_idle"}, 64'(we), 64'd0);
            @(negedge clk);
            chk({name, "_pulse_1cyc"}, 64'(mem_clr), 64'd0);
        end
        step();
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[9];
        int   exp_drop;
        int   cnt_lo;
        int   cnt_w;
        bit   found;

        for (int i = 0; i < 64; i++) model[i] = '0;
        vt[0] = '{x: 3,  y: 5,  c: 1'b1, acc: 1'b1, drp: 1'b0};
        vt[1] = '{x: 38, y: 39, c: 1'b1, acc: 1'b1, drp: 1'b0};
        vt[2] = '{x: 0,  y: 0,  c: 1'b1, acc: 1'b1, drp: 1'b0};
        vt[3] = '{x: 39, y: 2,  c: 1'b1, acc: 1'b0, drp: 1'b1};
        vt[4] = '{x: 1,  y: 40, c: 1'b1, acc: 1'b0, drp: 1'b1};
        vt[5] = '{x: 5,  y: 5,  c: 1'b0, acc: 1'b0, drp: 1'b0};
        vt[6] = '{x: 63, y: 63, c: 1'b1, acc: 1'b0, drp: 1'b1};
        vt[7] = '{x: 9,  y: 5,  c: 1'b1, acc: 1'b1, drp: 1'b0};
        vt[8] = '{x: 20, y: 40, c: 1'b0, acc: 1'b0, drp: 1'b0};

        // Reset state
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_raddr", 64'(raddr), 64'd0);
        chk("rst_waddr", 64'(waddr), 64'd0);
        chk("rst_wdata", 64'(wdata), 64'd0);
        chk("rst_we", 64'(we), 64'd0);
        chk("rst_frame_rdy", 64'(frame_rdy), 64'd0);
        chk("rst_mem_clr", 64'(mem_clr), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        reset = 1'b1;
        step();

        // Single hit, latency, drain, long hold, clear sweep
        sof();
        drive_hit(3, 5, 1'b1);
        expect_write(3, 5);
        step();
        chk("t1_raddr", 64'(raddr), 64'd6);
        idle_in();
        step();
        chk("t1_no_we_early", 64'(we), 64'd0);
        step();
        chk("t1_we", 64'(we), 64'd1);
        chk("t1_waddr", 64'(waddr), 64'd6);
        chk("t1_wdata", 64'(wdata), 64'h8);
        tag = EOF; step(); tag = '0; step();
        chk("t1_rdy_in_drain", 64'(frame_rdy), 64'd0);
        step();
        chk("t1_frame_rdy", 64'(frame_rdy), 64'd1);
        chk("t1_in_ready_hold", 64'(in_ready), 64'd0);
        cnt_lo = 0; cnt_w = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (!frame_rdy) cnt_lo++;
            if (we) cnt_w++;
        end
        chk("t1_hold_rdy_low_cycles", 64'(cnt_lo), 64'd0);
        chk("t1_hold_writes", 64'(cnt_w), 64'd0);
        rd_done = 1'b1; push_clear(); step(); rd_done = 1'b0;
        wait_memclr("clr1");

        // Same-row back-to-back and alternating rows (forwarding)
        sof();
        drive_hit(2, 7, 1'b1);  expect_write(2, 7);  step();
        drive_hit(9, 7, 1'b1);  expect_write(9, 7);  step();
        drive_hit(2, 7, 1'b1);  expect_write(2, 7);  step();
        drive_hit(4, 10, 1'b1); expect_write(4, 10); step();
        drive_hit(6, 11, 1'b1); expect_write(6, 11); step();
        drive_hit(5, 10, 1'b1); expect_write(5, 10); step();
        drive_hit(7, 11, 1'b1); expect_write(7, 11); step();
        idle_in();
        rd_done = 1'b1; step(); rd_done = 1'b0;
        repeat (3) step();
        eof_to_hold();
        chk("t2_row8", 64'(mem[8]), 64'h204);
        chk("t2_row11", 64'(mem[11]), 64'h30);
        chk("t2_row12", 64'(mem[12]), 64'hC0);
        drive_hit(3, 3, 1'b1);
        repeat (3) step();
        idle_in(); step();
        chk("t2_drop_in_hold", 64'(drop_cnt), 64'd3);
        chk("t2_still_rdy", 64'(frame_rdy), 64'd1);
        rd_done = 1'b1; push_clear(); step(); rd_done = 1'b0;
        wait_memclr("clr2");

        // Table of single hits: acceptance and drop accounting
        sof();
        chk("t3_sof_zero", 64'(drop_cnt), 64'd0);
        exp_drop = 0;
        for (int i = 0; i < 9; i++) begin
            drive_hit(vt[i].x, vt[i].y, vt[i].c);
            if (vt[i].acc) expect_write(vt[i].x, vt[i].y);
            step();
            idle_in();
            repeat (3) step();
            if (vt[i].drp) exp_drop++;
            chk($sformatf("t3_vec%0d_drop", i), 64'(drop_cnt), 64'(exp_drop));
            chk($sformatf("t3_vec%0d_writes", i), 64'(sb_q.size()), 64'd0);
        end
        // SOF with a hit in the same cycle: restart, no write, counter zeroed
        drive_hit(4, 4, 1'b1); tag = SOF; step();
        idle_in(); repeat (3) step();
        chk("t3_sof_restart_drop", 64'(drop_cnt), 64'd0);
        drive_hit(39, 0, 1'b1); step(); idle_in(); step();
        // EOF with a hit in the same cycle: neither written nor counted
        drive_hit(1, 1, 1'b1); tag = EOF; step();
        idle_in(); step(); step();
        chk("t3_eof_masked_drop", 64'(drop_cnt), 64'd1);
        chk("t3_eof_masked_write", 64'(sb_q.size()), 64'd0);
        chk("t3_hold_rdy", 64'(frame_rdy), 64'd1);
        drive_hit(0, 0, 1'b1);
        repeat (65540) step();
        idle_in(); step();
        chk("t3_drop_saturated", 64'(drop_cnt), 64'hFFFF);
        rd_done = 1'b1; push_clear(); step(); rd_done = 1'b0;
        wait_memclr("clr3");

        // EOF in IDLE is ignored
        tag = EOF; step(); tag = '0; step(); step();
        chk("t4_eof_idle_ready", 64'(in_ready), 64'd1);
        chk("t4_eof_idle_rdy", 64'(frame_rdy), 64'd0);

`ifdef HIT_FRAME_DECODER_ROWMASK_EN
        sof();
        drive_hit(0, 0, 1'b1);  expect_write(0, 0);  step();
        drive_hit(5, 39, 1'b1); expect_write(5, 39); step();
        idle_in(); repeat (3) step();
        eof_to_hold();
        chk("rm_bits", 64'(row_hit), (64'd1 << 39) | 64'd1);
        rd_done = 1'b1; push_clear(); step(); rd_done = 1'b0;
        chk("rm_clear_entry", 64'(row_hit), 64'd0);
        wait_memclr("clr_rm");
`endif

        // Asynchronous reset in the middle of the clear sweep
        sof();
        drive_hit(1, 2, 1'b1); expect_write(1, 2); step();
        idle_in(); repeat (3) step();
        eof_to_hold();
        rd_done = 1'b1; push_clear(); step(); rd_done = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (we && (waddr == AW'(20))) found = 1'b1;
        end
        chk("t5_reached_row20", 64'(found), 64'd1);
        #1;
        reset = 1'b0;
        sb_q.delete();
        #1;
        chk("t5_rst_we", 64'(we), 64'd0);
        chk("t5_rst_waddr", 64'(waddr), 64'd0);
        chk("t5_rst_wdata", 64'(wdata), 64'd0);
        chk("t5_rst_raddr", 64'(raddr), 64'd0);
        chk("t5_rst_frame_rdy", 64'(frame_rdy), 64'd0);
        chk("t5_rst_in_ready", 64'(in_ready), 64'd1);
        chk("t5_rst_drop", 64'(drop_cnt), 64'd0);
        cnt_w = 0;
        repeat (3) begin
            @(negedge clk);
            if (mem_clr) cnt_w++;
        end
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (mem_clr) cnt_w++;
        end
        chk("t5_no_mem_clr", 64'(cnt_w), 64'd0);
        sof();
        chk("t5_sof_accepted", 64'(in_ready), 64'd1);
        drive_hit(6, 3, 1'b1); expect_write(6, 3); step();
        idle_in(); repeat (3) step();
        chk("t5_post_reset_write", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
